// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared width codes, FSM states and access legality check for the lsu
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } lsu_state_e;

    // Unsigned widths only make sense for loads, so a store with funct3[2] set is illegal.
    function automatic logic access_illegal(input logic we, input logic [2:0] f3,
                                            input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b1;
        endcase
        if (we && f3[2]) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - data-memory req/gnt/rvalid bus between the lsu and data memory
interface lsu_if #(parameter int ADDR_W = 32);

    logic              dmem_req_o;
    logic              dmem_gnt_i;
    logic              dmem_we_o;
    logic [3:0]        dmem_be_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [31:0]       dmem_wdata_o;
    logic              dmem_rvalid_i;
    logic [31:0]       dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane steering, load extension and legality decode
module lsu_align
    import lsu_pkg::*;
(
    input  logic        st_we,
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_al,
    output logic        st_err,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Replicating the operand across lanes lets the byte enables alone pick the target lane.
    always_comb begin
        st_be       = 4'b1111;
        st_wdata_al = st_wdata;
        case (st_funct3[1:0])
            2'b00: begin
                st_be       = 4'b0001 << st_off;
                st_wdata_al = {4{st_wdata[7:0]}};
            end
            2'b01: begin
                st_be       = 4'b0011 << st_off;
                st_wdata_al = {2{st_wdata[15:0]}};
            end
            default: begin
                st_be       = 4'b1111;
                st_wdata_al = st_wdata;
            end
        endcase
    end

    assign st_err  = access_illegal(st_we, st_funct3, st_off);
    assign shifted = ld_rdata >> {ld_off, 3'b000};

    always_comb begin
        ld_data = 32'h0;
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    ld_data = shifted;
            F3_BU:   ld_data = {24'h0, shifted[7:0]};
            F3_HU:   ld_data = {16'h0, shifted[15:0]};
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit driving the data-memory bus
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_funct3_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [31:0]       lsu_wdata_i,
    output logic              lsu_done_o,
    output logic [31:0]       lsu_rdata_o,
    output logic              lsu_err_o,
    lsu_if.master             dmem
);

    lsu_state_e  state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic        acc_err;
    logic [31:0] ld_data;

    lsu_align u_align (
        .st_we       (lsu_we_i),
        .st_funct3   (lsu_funct3_i),
        .st_off      (lsu_addr_i[1:0]),
        .st_wdata    (lsu_wdata_i),
        .st_be       (be_n),
        .st_wdata_al (wdata_n),
        .st_err      (acc_err),
        .ld_funct3   (funct3_q),
        .ld_off      (off_q),
        .ld_rdata    (dmem.dmem_rdata_i),
        .ld_data     (ld_data)
    );

    assign lsu_ready_o = (state_q == IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= IDLE;
            funct3_q          <= 3'b000;
            off_q             <= 2'b00;
            lsu_done_o        <= 1'b0;
            lsu_err_o         <= 1'b0;
            lsu_rdata_o       <= 32'h0;
            dmem.dmem_req_o   <= 1'b0;
            dmem.dmem_we_o    <= 1'b0;
            dmem.dmem_be_o    <= 4'b0000;
            dmem.dmem_addr_o  <= '0;
            dmem.dmem_wdata_o <= 32'h0;
        end else begin
            lsu_done_o <= 1'b0;
            lsu_err_o  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lsu_valid_i) begin
                        funct3_q <= lsu_funct3_i;
                        off_q    <= lsu_addr_i[1:0];
                        // Rejected accesses report in the ERR cycle itself, so flag them now.
                        if (acc_err) begin
                            state_q     <= ERR;
                            lsu_done_o  <= 1'b1;
                            lsu_err_o   <= 1'b1;
                            lsu_rdata_o <= 32'h0;
                        end else begin
                            state_q           <= REQ;
                            dmem.dmem_req_o   <= 1'b1;
                            dmem.dmem_we_o    <= lsu_we_i;
                            dmem.dmem_be_o    <= be_n;
                            dmem.dmem_addr_o  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
                            dmem.dmem_wdata_o <= wdata_n;
                        end
                    end
                end
                REQ: begin
                    if (dmem.dmem_gnt_i) begin
                        dmem.dmem_req_o <= 1'b0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem.dmem_rvalid_i) begin
                        state_q     <= IDLE;
                        lsu_done_o  <= 1'b1;
                        lsu_rdata_o <= dmem.dmem_we_o ? 32'h0 : ld_data;
                    end
                end
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed scoreboard bench for the lsu
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic        lsu_we = 1'b0;
    logic [2:0]  lsu_funct3 = 3'b000;
    logic [31:0] lsu_addr = 32'h0;
    logic [31:0] lsu_wdata = 32'h0;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    lsu_if #(.ADDR_W(32)) dmem ();

    lsu #(.ADDR_W(32)) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .lsu_valid_i  (lsu_valid),
        .lsu_ready_o  (lsu_ready),
        .lsu_we_i     (lsu_we),
        .lsu_funct3_i (lsu_funct3),
        .lsu_addr_i   (lsu_addr),
        .lsu_wdata_i  (lsu_wdata),
        .lsu_done_o   (lsu_done),
        .lsu_rdata_o  (lsu_rdata),
        .lsu_err_o    (lsu_err),
        .dmem         (dmem.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, lsu_rdata, e.rdata);
            check({tag, "_err"}, {31'h0, lsu_err}, {31'h0, e.err});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'h0, lsu_ready}, 32'd1);
        check({tag, "_done"}, {31'h0, lsu_done}, 32'd0);
        check({tag, "_err"}, {31'h0, lsu_err}, 32'd0);
        check({tag, "_rdata"}, lsu_rdata, 32'h0);
        check({tag, "_req"}, {31'h0, dmem.dmem_req_o}, 32'd0);
        check({tag, "_we"}, {31'h0, dmem.dmem_we_o}, 32'd0);
        check({tag, "_be"}, {28'h0, dmem.dmem_be_o}, 32'h0);
        check({tag, "_addr"}, dmem.dmem_addr_o, 32'h0);
        check({tag, "_wdata"}, dmem.dmem_wdata_o, 32'h0);
    endtask

    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic exp_err, input logic [31:0] exp_rd);
        int start;
        int waited;
        waited = 0;
        @(negedge clk);
        while (!lsu_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready_before"}, {31'h0, lsu_ready}, 32'd1);
        lsu_valid  = 1'b1;
        lsu_we     = we;
        lsu_funct3 = f3;
        lsu_addr   = addr;
        lsu_wdata  = wdata;
        exp_q.push_back('{rdata: exp_rd, err: exp_err});
        start = cyc;
        @(posedge clk);
        #1 lsu_valid = 1'b0;
        @(negedge clk);
        check({tag, "_ready_busy"}, {31'h0, lsu_ready}, 32'd0);
        if (exp_err) begin
            check({tag, "_no_req"}, {31'h0, dmem.dmem_req_o}, 32'd0);
            check({tag, "_done"}, {31'h0, lsu_done}, 32'd1);
            pop_check(tag);
        end else begin
            check({tag, "_req"}, {31'h0, dmem.dmem_req_o}, 32'd1);
            check({tag, "_addr"}, dmem.dmem_addr_o, {addr[31:2], 2'b00});
            check({tag, "_be"}, {28'h0, dmem.dmem_be_o}, {28'h0, exp_be});
            check({tag, "_wdata"}, dmem.dmem_wdata_o, exp_wd);
            check({tag, "_we"}, {31'h0, dmem.dmem_we_o}, {31'h0, we});
            for (int i = 0; i < gnt_dly; i++) begin
                @(negedge clk);
                check({tag, "_req_hold"}, {31'h0, dmem.dmem_req_o}, 32'd1);
                check({tag, "_addr_hold"}, dmem.dmem_addr_o, {addr[31:2], 2'b00});
                check({tag, "_be_hold"}, {28'h0, dmem.dmem_be_o}, {28'h0, exp_be});
                check({tag, "_ready_hold"}, {31'h0, lsu_ready}, 32'd0);
                check({tag, "_done_early"}, {31'h0, lsu_done}, 32'd0);
            end
            dmem.dmem_gnt_i = 1'b1;
            @(posedge clk);
            #1 dmem.dmem_gnt_i = 1'b0;
            @(negedge clk);
            check({tag, "_req_dropped"}, {31'h0, dmem.dmem_req_o}, 32'd0);
            for (int i = 0; i < rv_dly; i++) begin
                @(negedge clk);
                check({tag, "_wait_done"}, {31'h0, lsu_done}, 32'd0);
                check({tag, "_wait_ready"}, {31'h0, lsu_ready}, 32'd0);
            end
            dmem.dmem_rvalid_i = 1'b1;
            dmem.dmem_rdata_i  = rdata;
            @(posedge clk);
            #1 dmem.dmem_rvalid_i = 1'b0;
            @(negedge clk);
            check({tag, "_done"}, {31'h0, lsu_done}, 32'd1);
            check({tag, "_ready_done"}, {31'h0, lsu_ready}, 32'd1);
            pop_check(tag);
            if (gnt_dly == 0 && rv_dly == 0)
                check({tag, "_latency"}, 32'(cyc - start), 32'd3);
        end
        @(negedge clk);
        check({tag, "_done_single"}, {31'h0, lsu_done}, 32'd0);
    endtask

    initial begin
        dmem.dmem_gnt_i    = 1'b0;
        dmem.dmem_rvalid_i = 1'b0;
        dmem.dmem_rdata_i  = 32'h0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        access("sw",   1'b1, F3_W,  32'h100, 32'hDEADBEEF, 0, 0, 32'h0,
               4'b1111, 32'hDEADBEEF, 1'b0, 32'h0);
        access("lb",   1'b0, F3_B,  32'h103, 32'h0, 0, 0, 32'h80FF_0000,
               4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80);
        access("lbu",  1'b0, F3_BU, 32'h103, 32'h0, 0, 0, 32'h80FF_0000,
               4'b1000, 32'h0, 1'b0, 32'h0000_0080);
        access("sh",   1'b1, F3_H,  32'h102, 32'h1234_ABCD, 0, 0, 32'h0,
               4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0);
        access("lhu",  1'b0, F3_HU, 32'h102, 32'h0, 0, 0, 32'hABCD_0000,
               4'b1100, 32'h0, 1'b0, 32'h0000_ABCD);
        access("lh",   1'b0, F3_H,  32'h100, 32'h0, 0, 0, 32'h0000_8001,
               4'b0011, 32'h0, 1'b0, 32'hFFFF_8001);
        access("sb",   1'b1, F3_B,  32'h101, 32'h0000_005A, 0, 0, 32'h0,
               4'b0010, 32'h5A5A_5A5A, 1'b0, 32'h0);
        access("lw_mis",  1'b0, F3_W,   32'h101, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 1'b1, 32'h0);
        access("f3_011",  1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 1'b1, 32'h0);
        access("sbu_ill", 1'b1, F3_BU,  32'h100, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 1'b1, 32'h0);
        access("lh_mis",  1'b0, F3_H,   32'h103, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 1'b1, 32'h0);
        access("lw_slow", 1'b0, F3_W,   32'h104, 32'h0, 4, 2, 32'h1234_5678,
               4'b1111, 32'h0, 1'b0, 32'h1234_5678);

        // Stray handshake pulses while idle must not produce a completion or a request.
        @(negedge clk);
        dmem.dmem_gnt_i    = 1'b1;
        dmem.dmem_rvalid_i = 1'b1;
        @(posedge clk);
        #1;
        dmem.dmem_gnt_i    = 1'b0;
        dmem.dmem_rvalid_i = 1'b0;
        @(negedge clk);
        check("idle_stray_done", {31'h0, lsu_done}, 32'd0);
        check("idle_stray_req", {31'h0, dmem.dmem_req_o}, 32'd0);

        // Abandon a load in WAIT via reset; its late response must be ignored.
        @(negedge clk);
        lsu_valid  = 1'b1;
        lsu_we     = 1'b0;
        lsu_funct3 = F3_W;
        lsu_addr   = 32'h200;
        @(posedge clk);
        #1 lsu_valid = 1'b0;
        @(negedge clk);
        check("rst_req_up", {31'h0, dmem.dmem_req_o}, 32'd1);
        dmem.dmem_gnt_i = 1'b1;
        @(posedge clk);
        #1 dmem.dmem_gnt_i = 1'b0;
        @(negedge clk);
        check("rst_in_wait", {31'h0, lsu_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        dmem.dmem_rvalid_i = 1'b1;
        dmem.dmem_rdata_i  = 32'hCAFE_F00D;
        @(posedge clk);
        #1 dmem.dmem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_late_rvalid_done", {31'h0, lsu_done}, 32'd0);
        end
        check_reset_outputs("rst_after");

        access("lw_recover", 1'b0, F3_W, 32'h300, 32'h0, 0, 0, 32'h0BAD_F00D,
               4'b1111, 32'h0, 1'b0, 32'h0BAD_F00D);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the MCU memory stage, directly downstream of the ALU: it takes the ALU result as the effective address, plus store data and funct3, and runs one aligned data-memory transaction over a req/gnt/rvalid handshake. It generates byte enables and replicated write data for stores, extracts and sign/zero-extends load data, and flags misaligned or illegal accesses without touching memory. One access is in flight at a time; the core stalls on `lsu_ready_o`.

## Interface
- `ADDR_W`, 32, address width (ALU result width)
- `clk_i`  in  1  clock, rising edge
- `rst_ni`  in  1  reset, asynchronous, active-low
- `lsu_valid_i`  in  1  access request from execute stage
- `lsu_ready_o`  out  1  unit can accept; high only in IDLE
- `lsu_we_i`  in  1  1 = store, 0 = load
- `lsu_funct3_i`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `lsu_addr_i`  in  ADDR_W  effective address (ALU sum)
- `lsu_wdata_i`  in  32  store data (rs2)
- `lsu_done_o`  out  1  one-cycle completion pulse
- `lsu_rdata_o`  out  32  extended load result, valid with `lsu_done_o`
- `lsu_err_o`  out  1  misaligned/illegal flag, valid with `lsu_done_o`
- `dmem_req_o`  out  1  memory request
- `dmem_gnt_i`  in  1  request accepted
- `dmem_we_o`  out  1  write enable
- `dmem_be_o`  out  4  byte enables
- `dmem_addr_o`  out  ADDR_W  word address, bits [1:0] = 0
- `dmem_wdata_o`  out  32  aligned write data
- `dmem_rvalid_i`  in  1  response valid (loads and stores)
- `dmem_rdata_i`  in  32  read word

## Operation
- States: IDLE, REQ, WAIT, ERR.
- IDLE: accept on `lsu_valid_i & lsu_ready_o`; register we, funct3, addr, wdata, offset = addr[1:0].
- Check on accept: H/HU with addr[0]=1, W with addr[1:0]≠0, funct3 ∈ {011,110,111}, or store with funct3[2]=1 → ERR; else → REQ.
- REQ: `dmem_req_o`=1, address/be/we/wdata stable until `dmem_gnt_i`; on gnt → WAIT.
- WAIT: on `dmem_rvalid_i` → IDLE; register load result, pulse done.
- ERR: no memory request; → IDLE, pulse done with `lsu_err_o`=1, `lsu_rdata_o`=0.
- Store: SB be = 0001<<off, data = {4{b}}; SH be = 0011<<off, data = {2{h}}; SW be = 1111.
- Load: word = `dmem_rdata_i` >> 8·off; B/H sign-extend bit 7/15, BU/HU zero-extend, W passthrough. Store completion returns `lsu_rdata_o`=0.
- `dmem_rvalid_i` outside WAIT and `dmem_gnt_i` outside REQ are ignored.

## Timing
- Reset: state IDLE; `lsu_done_o`, `lsu_err_o`, `dmem_req_o`, `dmem_we_o` = 0; `lsu_rdata_o`, `dmem_be_o`, `dmem_addr_o`, `dmem_wdata_o` = 0; `lsu_ready_o` = 1.
- All outputs registered or decoded from registered state; no comb path input→output.
- Min latency: accept edge E0; req high cycle after E0; gnt same cycle → WAIT at E1; rvalid sampled E2; done high cycle after E2 (3 cycles accept→done).
- Error latency: done+err high the cycle after accept.
- `lsu_ready_o` low from accept until the done cycle; new accept allowed on the edge ending the done cycle.
- `lsu_done_o` exactly one cycle per accepted access.
- Reset mid-access: abandon, `dmem_req_o` drops asynchronously, late rvalid ignored.

## Structure
- Package `lsu_pkg`: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), `lsu_state_e` enum (IDLE/REQ/WAIT/ERR).
- Sub-module `lsu_align`: pure combinational be/wdata generation, load extraction/extension, misalign detect; FSM and registers in `lsu`.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, gnt/rvalid immediate → dmem_addr 0x100, be 1111, wdata 0xDEADBEEF; done 3 cycles after accept, err 0.
- LB addr 0x103, rdata 0x80FF_0000 → be 1000, rdata_o 0xFFFF_FF80; LBU same → 0x0000_0080.
- SH addr 0x102, wdata 0x1234_ABCD → be 1100, wdata 0xABCD_ABCD; LHU addr 0x102, rdata 0xABCD_0000 → 0x0000_ABCD.
- LW addr 0x101 → no dmem_req, done+err cycle after accept, rdata_o 0; funct3 011 → same.
- gnt held low 4 cycles then rvalid 2 cycles later → req/addr/be stable throughout, ready low, single done pulse.
- rst_ni low during WAIT, rvalid arrives after release → no done, ready 1, all outputs at reset values.
